// File: rtl/accel_seg_display.sv
// Eight-anode, active-low seven-segment scanner for the BCD acceleration readout (milli-g, sign digit).
// Optional build macro ACCEL_G_UNITS_EN switches to X.XXX g display with a decimal point after digit 3.
module accel_seg_display #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    input  logic       negative,
    output logic [7:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    // state | meaning
    // BLANK | first BLANK_CYC cycles of a slot, all anodes off
    // DRIVE | remainder of the slot, one anode on with its pattern

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [2:0]    SLOT_LAST = 3'd4;

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t      state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [2:0]  slot;
    logic [3:0]  sh_on, sh_te, sh_hu, sh_th;
    logic        sh_neg;

    logic        show_th, show_hu, show_te, mag_nz;
    logic [6:0]  seg_pat;
    logic        dp_pat;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0: p = 7'h40;
            4'd1: p = 7'h79;
            4'd2: p = 7'h24;
            4'd3: p = 7'h30;
            4'd4: p = 7'h19;
            4'd5: p = 7'h12;
            4'd6: p = 7'h02;
            4'd7: p = 7'h78;
            4'd8: p = 7'h00;
            4'd9: p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    assign cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    assign mag_nz  = |{sh_th, sh_hu, sh_te, sh_on};

    always_comb begin
`ifdef ACCEL_G_UNITS_EN
        show_th = 1'b1;
        show_hu = 1'b1;
        show_te = 1'b1;
        dp_pat  = (slot == 3'd3) ? 1'b0 : 1'b1;
`else
        // leading-zero blanking cascades down from the MSD
        show_th = (sh_th != 4'd0);
        show_hu = show_th || (sh_hu != 4'd0);
        show_te = show_hu || (sh_te != 4'd0);
        dp_pat  = 1'b1;
`endif
        seg_pat = 7'h7F;
        case (slot)
            3'd0: seg_pat = decode(sh_on);
            3'd1: if (show_te) seg_pat = decode(sh_te);
            3'd2: if (show_hu) seg_pat = decode(sh_hu);
            3'd3: if (show_th) seg_pat = decode(sh_th);
            3'd4: if (sh_neg && mag_nz) seg_pat = 7'h3F;
            default: seg_pat = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BLANK;
            cnt    <= '0;
            slot   <= 3'd0;
            sh_on  <= 4'd0;
            sh_te  <= 4'd0;
            sh_hu  <= 4'd0;
            sh_th  <= 4'd0;
            sh_neg <= 1'b0;
            an     <= 8'hFF;
            seg    <= 7'h7F;
            dp     <= 1'b1;
        end else begin
            if (load) begin
                sh_on  <= ones;
                sh_te  <= tens;
                sh_hu  <= hundreds;
                sh_th  <= thousands;
                sh_neg <= negative;
            end

            cnt <= cnt_nxt;
            if (cnt == CNT_LAST)
                slot <= (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;

            // state always mirrors the counter position within the slot
            case (state)
                BLANK: if (cnt_nxt >= BLANK_END) state <= DRIVE;
                DRIVE: if (cnt_nxt < BLANK_END) state <= BLANK;
                default: state <= BLANK;
            endcase

            if (state == DRIVE) begin
                an  <= ~(8'b1 << slot);
                seg <= seg_pat;
                dp  <= dp_pat;
            end else begin
                an  <= 8'hFF;
                seg <= 7'h7F;
                dp  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_accel_seg_display.sv
// Bench for accel_seg_display: per-cycle comparison against a frame-position reference model.
module tb_accel_seg_display;

    localparam int SD = 8;
    localparam int BC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load = 1'b0;
    logic [3:0] ones = 4'd0, tens = 4'd0, hundreds = 4'd0, thousands = 4'd0;
    logic       negative = 1'b0;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad = 0;
    int n = 0;
    logic [3:0] md[4];
    logic       mneg;
    logic [6:0] pat[10];

    accel_seg_display #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .ones(ones), .tens(tens), .hundreds(hundreds), .thousands(thousands),
        .negative(negative), .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Expected {an,seg,dp} after the edge that is cycle `cyc` since reset release.
    function automatic logic [15:0] model_out(int cyc);
        int s, c;
        logic [7:0] a;
        logic [6:0] sg;
        logic d;
        logic shown;
        s = (cyc / SD) % 5;
        c = cyc % SD;
        if (c < BC) return {8'hFF, 7'h7F, 1'b1};
        a = 8'hFF;
        a[s] = 1'b0;
        sg = 7'h7F;
        d = 1'b1;
        if (s < 4) begin
            shown = (s == 0);
            for (int k = s; k < 4; k++) if (md[k] != 4'd0) shown = 1'b1;
`ifdef ACCEL_G_UNITS_EN
            shown = 1'b1;
            if (s == 3) d = 1'b0;
`endif
            if (shown && md[s] <= 4'd9) sg = pat[md[s]];
        end else if (mneg && (md[0] != 0 || md[1] != 0 || md[2] != 0 || md[3] != 0)) begin
            sg = 7'h3F;
        end
        return {a, sg, d};
    endfunction

    task automatic step(output logic [15:0] exp);
        @(posedge clk);
        exp = model_out(n);
        if (load) begin
            md[0] = ones; md[1] = tens; md[2] = hundreds; md[3] = thousands;
            mneg = negative;
        end
        n++;
        #1;
    endtask

    task automatic set_in(input logic [3:0] th, hu, te, on, input logic ng);
        thousands = th; hundreds = hu; tens = te; ones = on; negative = ng;
    endtask

    task automatic model_reset();
        n = 0;
        for (int k = 0; k < 4; k++) md[k] = 4'd0;
        mneg = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL reset_async got an=%h seg=%h dp=%b want an=ff seg=7f dp=1", an, seg, dp);
        end
        @(posedge clk); #1;
        total++;
        if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL reset_held got an=%h seg=%h dp=%b want an=ff seg=7f dp=1", an, seg, dp);
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_no_load();
        logic [15:0] exp;
        for (int i = 0; i < 5 * SD; i++) begin
            step(exp);
            total++;
            if ({an, seg, dp} !== exp) begin
                bad++;
                $display("FAIL no_load cyc=%0d got %h/%h/%b want %h/%h/%b", n-1, an, seg, dp, exp[15:8], exp[7:1], exp[0]);
            end
            if (i == BC) begin
                total++;
                if (an !== 8'hFE || seg !== 7'h40) begin
                    bad++;
                    $display("FAIL first_drive got an=%h seg=%h want an=fe seg=40", an, seg);
                end
            end
        end
    endtask

    task automatic test_loads();
        logic [15:0] exp;
        logic [16:0] vec[3];
        vec[0] = {4'd2, 4'd0, 4'd4, 4'd4, 1'b1};
        vec[1] = {4'd0, 4'd0, 4'd1, 4'd2, 1'b1};
        vec[2] = {4'd0, 4'd0, 4'd0, 4'd0, 1'b1};
        for (int v = 0; v < 3; v++) begin
            set_in(vec[v][16:13], vec[v][12:9], vec[v][8:5], vec[v][4:1], vec[v][0]);
            load = 1'b1;
            step(exp);
            load = 1'b0;
            for (int i = 0; i < 5 * SD + 1; i++) begin
                step(exp);
                total++;
                if ({an, seg, dp} !== exp || an[7:5] !== 3'b111) begin
                    bad++;
                    $display("FAIL load_vec%0d cyc=%0d got %h/%h/%b want %h/%h/%b", v, n-1, an, seg, dp, exp[15:8], exp[7:1], exp[0]);
                end
            end
        end
    endtask

    task automatic test_hold_and_boundary();
        logic [15:0] exp;
        int guard;
        set_in(4'd9, 4'd8, 4'd7, 4'd6, 1'b1);
        for (int i = 0; i < 5 * SD; i++) begin
            step(exp);
            total++;
            if ({an, seg, dp} !== exp) begin
                bad++;
                $display("FAIL hold cyc=%0d got %h/%h/%b want %h/%h/%b", n-1, an, seg, dp, exp[15:8], exp[7:1], exp[0]);
            end
        end
        guard = 0;
        while (n % SD != SD - 1 && guard < 2 * SD) begin
            step(exp);
            guard++;
        end
        total++;
        if (guard >= 2 * SD) begin
            bad++;
            $display("FAIL boundary_sync got timeout want slot end");
        end
        load = 1'b1;
        step(exp);
        load = 1'b0;
        set_in(4'd0, 4'd0, 4'd0, 4'd1, 1'b0);
        for (int i = 0; i < 2 * SD; i++) begin
            step(exp);
            total++;
            if ({an, seg, dp} !== exp) begin
                bad++;
                $display("FAIL boundary_load cyc=%0d got %h/%h/%b want %h/%h/%b", n-1, an, seg, dp, exp[15:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        int guard = 0;
        while (!((n / SD) % 5 == 3 && n % SD == BC + 2) && guard < 10 * SD) begin
            step(exp);
            guard++;
        end
        total++;
        if (guard >= 10 * SD || an !== 8'hF7) begin
            bad++;
            $display("FAIL reset_mid_setup got an=%h want f7", an);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid got an=%h seg=%h dp=%b want an=ff seg=7f dp=1", an, seg, dp);
        end
        @(negedge clk) rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3 * SD; i++) begin
            step(exp);
            total++;
            if ({an, seg, dp} !== exp) begin
                bad++;
                $display("FAIL after_reset cyc=%0d got %h/%h/%b want %h/%h/%b", n-1, an, seg, dp, exp[15:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_g_units();
        logic [15:0] exp;
        set_in(4'd0, 4'd5, 4'd1, 4'd2, 1'b0);
        load = 1'b1;
        step(exp);
        load = 1'b0;
        for (int i = 0; i < 5 * SD + 1; i++) begin
            step(exp);
            total++;
            if ({an, seg, dp} !== exp) begin
                bad++;
                $display("FAIL g_vec cyc=%0d got %h/%h/%b want %h/%h/%b", n-1, an, seg, dp, exp[15:8], exp[7:1], exp[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] exp;
        logic [3:0] d[4];
        int r;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 4; k++) begin
                r = $urandom_range(0, 15);
                d[k] = (r < 6) ? 4'd0 : (r < 15) ? 4'($urandom_range(1, 9)) : 4'($urandom_range(10, 15));
            end
            set_in(d[3], d[2], d[1], d[0], 1'($urandom_range(0, 1)));
            load = ($urandom_range(0, 3) == 0);
            step(exp);
            total++;
            if ({an, seg, dp} !== exp) begin
                bad++;
                $display("FAIL random cyc=%0d got %h/%h/%b want %h/%h/%b", n-1, an, seg, dp, exp[15:8], exp[7:1], exp[0]);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
        pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;
        model_reset();
        test_reset();
        test_no_load();
        test_loads();
        test_hold_and_boundary();
        test_reset_mid();
        test_g_units();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
